// File: rtl/shamt_shifter_seq_pkg.sv
// Shared codes for the multi-cycle shift unit: shift ops, amount sources, FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    SA_IMM   = 2'b00,
    SA_CONST = 2'b01,
    SA_REG   = 2'b10,
    SA_B     = 2'b11
  } shamt_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shamt_shifter_seq_shift_step.sv
// One iteration of the shifter: moves WIDTH bits by k (0..STEP) positions per op.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] d,
  input  shift_op_e        op,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] q
);

  logic [2*WIDTH-1:0] rot_full;

  // Rotate via a doubled copy so k=0 needs no special case.
  assign rot_full = {d, d} >> k;

  // Per-op shift of the current partial result.
  always_comb begin
    q = d;
    unique case (op)
      SH_SLL: q = d << k;
      SH_SRL: q = d >> k;
      SH_SRA: q = $unsigned($signed(d) >>> k);
      SH_ROR: q = rot_full[WIDTH-1:0];
      default: q = d;
    endcase
  end

endmodule

// File: rtl/shamt_shifter_seq.sv
// Multi-cycle shift unit: picks a shift amount from four sources, then shifts the
// latched operand by up to STEP bits per cycle with a start/busy/done handshake.
module shamt_shifter_seq
  import shifter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SHAMT_W     = $clog2(WIDTH),
  parameter int STEP        = 1,
  parameter int CONST_SHAMT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         shamt_sel,
  input  logic [1:0]         shift_op,
  input  logic [SHAMT_W-1:0] imm_shamt,
  input  logic [WIDTH-1:0]   reg_shamt,
  input  logic [WIDTH-1:0]   b_shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out,
  output logic [SHAMT_W-1:0] shamt_used
);

  localparam int KW = $clog2(STEP + 1);
  // Compare in SHAMT_W+1 bits so STEP == WIDTH still fits.
  localparam logic [SHAMT_W:0] STEP_V = (SHAMT_W + 1)'(STEP);

  state_e             state;
  shift_op_e          op_q;
  logic [SHAMT_W-1:0] remaining;
  logic [SHAMT_W-1:0] amt;
  logic [SHAMT_W:0]   rem_ext;
  logic [SHAMT_W:0]   k_ext;
  logic [SHAMT_W:0]   rem_next_ext;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   step_q;
  logic               accept;
  logic               unused_hi;

  // Only the low SHAMT_W bits of the register sources matter.
  assign unused_hi = ^{reg_shamt[WIDTH-1:SHAMT_W], b_shamt[WIDTH-1:SHAMT_W]};

  // Shift-amount source select.
  always_comb begin
    amt = imm_shamt;
    unique case (shamt_sel_e'(shamt_sel))
      SA_IMM:   amt = imm_shamt;
      SA_CONST: amt = SHAMT_W'(CONST_SHAMT);
      SA_REG:   amt = reg_shamt[SHAMT_W-1:0];
      SA_B:     amt = b_shamt[SHAMT_W-1:0];
      default:  amt = imm_shamt;
    endcase
  end

  // Per-cycle step size k = min(STEP, remaining) and what is left after it.
  always_comb begin
    rem_ext      = {1'b0, remaining};
    k_ext        = (rem_ext < STEP_V) ? rem_ext : STEP_V;
    rem_next_ext = rem_ext - k_ext;
    k            = k_ext[KW-1:0];
  end

  assign accept = start && (state != ST_SHIFT);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .d  (data_out),
    .op (op_q),
    .k  (k),
    .q  (step_q)
  );

  // Control FSM with registered busy/done decodes and the datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_out   <= '0;
      shamt_used <= '0;
      remaining  <= '0;
      op_q       <= SH_SLL;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            data_out   <= data_in;
            op_q       <= shift_op_e'(shift_op);
            remaining  <= amt;
            shamt_used <= amt;
            if (amt != '0) begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          data_out  <= step_q;
          remaining <= rem_next_ext[SHAMT_W-1:0];
          if (rem_next_ext == '0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
